// File: rtl/ether_tx_pkg.sv
// Shared types and Ethernet framing constants for the transmit scheduler.
package ether_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_GAP  = 3'd4
  } etx_sched_state_t;

  localparam int PREAMBLE_SFD_BITS = 64;
  localparam int HDR_BITS          = 112;
  localparam int IFG_BITS          = 96;
  localparam int MIN_PAYLOAD_BITS  = 368;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ether_tx_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner, pointer remembers the
// last winner and moves only on a take strobe.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  logic [IDX_W-1:0] r_last;
  logic             w_found_hi;
  logic             w_found_lo;
  logic [IDX_W-1:0] w_idx_hi;
  logic [IDX_W-1:0] w_idx_lo;

  // Prefer the first requester above the last winner; otherwise wrap to the lowest.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_idx_hi   = '0;
    w_idx_lo   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j] && !w_found_lo) begin
        w_found_lo = 1'b1;
        w_idx_lo   = IDX_W'(j);
      end
      if (req[j] && (IDX_W'(j) > r_last) && !w_found_hi) begin
        w_found_hi = 1'b1;
        w_idx_hi   = IDX_W'(j);
      end
    end
    winner_idx = w_found_hi ? w_idx_hi : w_idx_lo;
    winner     = '0;
    if (|req) winner[winner_idx] = 1'b1;
  end

  // Reset to the top index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IDX_W'(NUM_REQ - 1);
    end else if (take) begin
      r_last <= winner_idx;
    end
  end

endmodule

// File: rtl/ether_tx_sched.sv
// Shares one Ethernet TX serializer between NUM_REQ frame sources.
// Optional ETH_TX_PAD_EN: zero-pad payloads shorter than the 46-byte minimum.
module ether_tx_sched
  import ether_tx_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int N          = 2,
  parameter int IFG_CYCLES = IFG_BITS / N,
  parameter int HDR_CYCLES = (PREAMBLE_SFD_BITS + HDR_BITS) / N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*N-1:0]  src_data,
  input  logic [NUM_REQ-1:0]    src_valid,
  input  logic [NUM_REQ-1:0]    src_last,
  input  logic [NUM_REQ*16-1:0] src_etype,
  input  logic [NUM_REQ*48-1:0] src_dest_mac,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    src_ready,
  output logic                  tx_valid,
  output logic [N-1:0]          tx_data,
  output logic [15:0]           tx_etype,
  output logic [47:0]           tx_dest_mac,
  output logic                  frame_done,
  output logic                  underrun,
  output etx_sched_state_t      dbg_state
);

  localparam int          IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] HDR_LAST = 16'(HDR_CYCLES);
  localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);
`ifdef ETH_TX_PAD_EN
  localparam logic [15:0] MIN_BEATS = 16'(MIN_PAYLOAD_BITS / N);
`endif

  etx_sched_state_t r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic               r_tx_valid, w_tx_valid_nxt;
  logic [N-1:0]       r_tx_data, w_tx_data_nxt;
  logic [15:0]        r_etype, w_etype_nxt;
  logic [47:0]        r_mac, w_mac_nxt;
  logic               r_frame_done, w_frame_done_nxt;
  logic               r_underrun, w_underrun_nxt;
  logic [15:0]        r_hdr_cnt, w_hdr_cnt_nxt;
  logic [15:0]        r_gap_cnt, w_gap_cnt_nxt;
  logic [15:0]        r_beat_cnt, w_beat_cnt_nxt;
  logic [15:0]        w_beat_inc;

  logic [NUM_REQ-1:0] w_arb_winner;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_take;

  logic [15:0]  w_etype_arr [NUM_REQ];
  logic [47:0]  w_mac_arr   [NUM_REQ];
  logic [N-1:0] w_data_arr  [NUM_REQ];
  logic         w_own_valid;
  logic         w_own_last;
  logic [N-1:0] w_own_data;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
    assign w_etype_arr[gi] = src_etype[gi*16 +: 16];
    assign w_mac_arr[gi]   = src_dest_mac[gi*48 +: 48];
    assign w_data_arr[gi]  = src_data[gi*N +: N];
  end

  assign w_own_valid = src_valid[r_owner];
  assign w_own_last  = src_last[r_owner];
  assign w_own_data  = w_data_arr[r_owner];
  assign w_beat_inc  = sat_inc16(r_beat_cnt);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .take       (w_take),
    .winner     (w_arb_winner),
    .winner_idx (w_arb_idx)
  );

  // Payload handshake: a beat moves when src_valid & src_ready are both high
  // in the same cycle. src_ready is high for the owner throughout DATA; the
  // serializer cannot stall, so a DATA cycle without src_valid aborts the frame.
  assign src_ready   = r_grant & {NUM_REQ{r_state == ST_DATA}};
  assign grant       = r_grant;
  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign tx_etype    = r_etype;
  assign tx_dest_mac = r_mac;
  assign frame_done  = r_frame_done;
  assign underrun    = r_underrun;
  assign dbg_state   = r_state;

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_owner_nxt      = r_owner;
    w_tx_valid_nxt   = 1'b0;
    w_tx_data_nxt    = '0;
    w_etype_nxt      = r_etype;
    w_mac_nxt        = r_mac;
    w_frame_done_nxt = 1'b0;
    w_underrun_nxt   = 1'b0;
    w_hdr_cnt_nxt    = r_hdr_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_take           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_take         = 1'b1;
          w_grant_nxt    = w_arb_winner;
          w_owner_nxt    = w_arb_idx;
          w_etype_nxt    = w_etype_arr[w_arb_idx];
          w_mac_nxt      = w_mac_arr[w_arb_idx];
          w_tx_valid_nxt = 1'b1;
          w_hdr_cnt_nxt  = '0;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_HDR;
        end
      end

      // Serializer emits preamble/SFD/MACs/type itself; we only hold the path.
      ST_HDR: begin
        w_tx_valid_nxt = 1'b1;
        w_hdr_cnt_nxt  = r_hdr_cnt + 16'd1;
        if (r_hdr_cnt == HDR_LAST) w_state_nxt = ST_DATA;
      end

      ST_DATA: begin
        if (w_own_valid) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = w_own_data;
          w_beat_cnt_nxt = w_beat_inc;
          if (w_own_last) begin
`ifdef ETH_TX_PAD_EN
            if (w_beat_inc < MIN_BEATS) begin
              w_state_nxt = ST_PAD;
            end else begin
              w_state_nxt      = ST_GAP;
              w_grant_nxt      = '0;
              w_gap_cnt_nxt    = '0;
              w_frame_done_nxt = 1'b1;
            end
`else
            w_state_nxt      = ST_GAP;
            w_grant_nxt      = '0;
            w_gap_cnt_nxt    = '0;
            w_frame_done_nxt = 1'b1;
`endif
          end
        end else begin
          w_underrun_nxt = 1'b1;
          w_state_nxt    = ST_GAP;
          w_grant_nxt    = '0;
          w_gap_cnt_nxt  = '0;
        end
      end

`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        w_tx_valid_nxt = 1'b1;
        w_beat_cnt_nxt = w_beat_inc;
        if (w_beat_inc >= MIN_BEATS) begin
          w_state_nxt      = ST_GAP;
          w_grant_nxt      = '0;
          w_gap_cnt_nxt    = '0;
          w_frame_done_nxt = 1'b1;
        end
      end
`endif

      // The first GAP cycle still carries the final beat; it counts toward the gap.
      ST_GAP: begin
        w_gap_cnt_nxt = r_gap_cnt + 16'd1;
        if (r_gap_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_owner      <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_etype      <= '0;
      r_mac        <= '0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_hdr_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_beat_cnt   <= '0;
    end else begin
      r_grant      <= w_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_etype      <= w_etype_nxt;
      r_mac        <= w_mac_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_underrun   <= w_underrun_nxt;
      r_hdr_cnt    <= w_hdr_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
    end
  end

endmodule

// File: doc/ether_tx_sched.md
# ether_tx_sched

Transmit scheduler that shares the single Ethernet transmit path between `NUM_REQ` frame sources. It picks one requester by round-robin and latches that requester's destination MAC and ethertype. It then kicks the transmitter and holds off the source's payload until the preamble, SFD and header have gone out. Finally it streams the payload and enforces the inter-frame gap before it arbitrates again. It sits between the packet sources (controller/video packers) and the Ethernet TX serializer.

## Interface
Parameters:
- `NUM_REQ`, 2, number of frame sources.
- `N`, 2, data beat width in bits (2 or 4; RMII dibit or nibble).
- `IFG_CYCLES`, 96/N, inter-frame gap length in clk cycles.
- `HDR_CYCLES`, 176/N, cycles the serializer spends on preamble+SFD+MACs+type after kick.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req` in NUM_REQ: per-source frame request; held until grant.
- `src_data` in NUM_REQ*N: per-source payload beats; source i occupies bits [i*N +: N].
- `src_valid` in NUM_REQ: per-source beat valid.
- `src_last` in NUM_REQ: marks a source's final payload beat.
- `src_etype` in NUM_REQ*16: per-source ethertype.
- `src_dest_mac` in NUM_REQ*48: per-source destination MAC.
- `grant` out NUM_REQ: one-hot owner; zero when idle.
- `src_ready` out NUM_REQ: payload accept, equal to grant & (state==DATA).
- `tx_valid` out 1: drives serializer `axiiv`.
- `tx_data` out N: drives serializer `axiid`.
- `tx_etype` out 16: latched ethertype of the owner.
- `tx_dest_mac` out 48: latched destination MAC of the owner.
- `frame_done` out 1: one-cycle pulse when a frame ends normally.
- `underrun` out 1: one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, HDR, DATA, (PAD), GAP.
- IDLE: if any `req` is set, register the round-robin winner into `grant`. The search starts at index last_winner+1 and wraps modulo NUM_REQ. Latch the winner's etype and dest MAC, set `tx_valid`=1, clear hdr_cnt, and go to HDR.
- HDR: `tx_valid`=1 and `tx_data`=0. Increment hdr_cnt. After HDR_CYCLES cycles, go to DATA.
- DATA: `src_ready` is asserted for the owner.
  - On a beat with `src_valid`: next cycle `tx_data`=beat and `tx_valid`=1; beat_cnt increments (saturating at 16 bits).
  - On `src_valid`&`src_last`: the frame ends. Go to PAD if ETH_TX_PAD_EN is defined and the minimum is not met; otherwise go to GAP and pulse `frame_done`.
  - If `src_valid` is low in DATA: `underrun` pulses, `tx_valid` drops next cycle, and the state goes to GAP. The MAC cannot stall.
- GAP: `tx_valid`=0 and `grant` is cleared. Count IFG_CYCLES, then go to IDLE. Requests arriving during GAP wait.
- `tx_etype` and `tx_dest_mac` stay stable from grant until GAP ends.
- Round-robin pointer: updated only on grant; reset value selects req0 first.

## Timing
- Reset values: `grant`, `src_ready`, `tx_valid`, `tx_data`, `frame_done` and `underrun` are 0; `tx_etype` and `tx_dest_mac` are 0; pointer favours req0.
- `rst` mid-frame: IDLE on the next edge with all outputs at reset values. No completion pulse.
- Latency:
  - `req` to `grant`/`tx_valid` is 1 cycle.
  - First `src_ready` comes HDR_CYCLES+1 cycles after `grant`.
  - Source beat to `tx_data` is 1 cycle, registered.
- Frame-to-frame spacing: the minimum is IFG_CYCLES idle cycles of `tx_valid`=0.
- Simultaneous requests: exactly one grant, with no idle cycle lost to arbitration.
- A requester withdrawing `req` after grant has no effect; the frame proceeds.

## Configuration
- `ETH_TX_PAD_EN` defined: if a frame ends before MIN_BEATS=368/N payload beats (46 bytes), enter PAD. PAD drives `tx_data`=0 with `tx_valid`=1 until beat_cnt reaches MIN_BEATS, then goes to GAP and pulses `frame_done`.
- Undefined: no PAD state; short frames go out as supplied.

## Structure
- Package `ether_tx_pkg`:
  - state enum `etx_sched_state_t`;
  - constants PREAMBLE_SFD_BITS=64, HDR_BITS=112, IFG_BITS=96, MIN_PAYLOAD_BITS=368.
- Sub-module `rr_arbiter`: parameterized on NUM_REQ. It takes `req` and the pointer, returns a one-hot winner, and advances the pointer on a `take` strobe.

## Test plan
- Single request, req0=1 with a 200-beat payload (N=2): grant=01 one cycle later, first `src_ready` 89 cycles after grant, 200 beats on `tx_data` with 1-cycle lag, then `frame_done`, then 48 idle cycles.
- Both requesters held high: grants alternate 01, 10, 01. Each frame is separated by exactly IFG_CYCLES with `tx_valid`=0.
- `src_valid` drops at beat 50: `underrun` pulses, `tx_valid`=0 next cycle, GAP is entered, and no `frame_done`.
- With ETH_TX_PAD_EN, a 10-beat frame: 174 zero beats follow, 184 beats total, then `frame_done`. Without the macro: 10 beats, then `frame_done`.
- `rst` asserted during HDR: next cycle all outputs are 0. After reset, req1 and req0 are both asserted and req0 is granted first.
- Per-source MACs are 0x0A0B0C0D0E0F and 0x112233445566: `tx_dest_mac` matches the owner and stays stable through GAP.
